uart_rx_frame_parser: RTL
=========================

Name: uart_rx_frame_parser

Overview:
- Downstream consumer of the UART receiver. Takes its byte output (rx_data qualified by rx_done) and assembles framed commands: SYNC, LEN, LEN payload bytes, CSUM.
- Payload is buffered internally and released only after the checksum verifies, as a valid/ready byte stream with a last marker.
- Malformed frames, checksum failures, inter-byte timeouts and bytes arriving while a frame is draining are flagged with single-cycle error pulses.

Parameters:
MAX_LEN, 16, payload buffer depth in bytes; legal LEN range is 1..MAX_LEN
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CLKS, 8680, clocks allowed between bytes inside a frame (20 bit times at 434 clk/bit)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
rx_data  input  8  received byte from UART receiver
rx_done  input  1  byte-complete flag from UART receiver (may stay high for more than one cycle)
out_data  output  8  payload byte
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_last  output  1  current out_data is the final payload byte
frame_len  output  8  LEN of the frame being drained; held until the next frame_ok
frame_ok  output  1  1-cycle pulse: checksum matched, drain starts
err_len  output  1  1-cycle pulse: LEN is 0 or greater than MAX_LEN
err_csum  output  1  1-cycle pulse: checksum mismatch
err_timeout  output  1  1-cycle pulse: inter-byte timeout
overrun  output  1  1-cycle pulse: byte received during DRAIN and dropped

Behaviour:
- Reset (rst=0, async): state HUNT; all outputs 0; counters and checksum 0.
- rx_done_d resets to 1, so an rx_done already high at reset release is not taken as a byte.
- Byte event = rx_done & ~rx_done_d, registered every clk. rx_data is sampled in the event cycle. One event per rx_done high period.
- HUNT: on an event with byte == SYNC_BYTE -> LEN. Other bytes are silently discarded.
- LEN, on an event:
  - byte 0 or byte > MAX_LEN: pulse err_len, -> HUNT.
  - otherwise: store len, sum = byte, idx = 0, -> PAYLOAD.
- PAYLOAD, on an event: buf[idx] = byte; sum = sum + byte (mod 256); idx++. When idx reaches len -> CSUM.
- CSUM, on an event:
  - byte == sum: frame_len = len, pulse frame_ok, idx = 0, -> DRAIN.
  - else: pulse err_csum, -> HUNT.
- Flags pulse in the cycle after the event, i.e. registered, 1-cycle latency.
- Timeout:
  - Counter clears on every event and on entering LEN.
  - It counts only in LEN, PAYLOAD and CSUM.
  - When it reaches TIMEOUT_CLKS-1 with no event in that cycle: pulse err_timeout, -> HUNT, discard partial frame.
  - If an event and expiry coincide, the event wins.
- DRAIN:
  - out_valid = 1, out_data = buf[idx], out_last = (idx == len-1).
  - Transfer on out_valid & out_ready: idx++. Transfer with out_last -> HUNT, out_valid = 0 next cycle.
  - out_data and out_last are stable while out_valid & ~out_ready; no timeout applies.
  - Any event during DRAIN: byte dropped, pulse overrun. A dropped SYNC is not reinterpreted.
- A SYNC_BYTE value inside LEN, PAYLOAD or CSUM is ordinary data, with no resync.
- Throughput: after the first transfer, one payload byte per clk when out_ready is held high.
- Mid-frame reset: immediately HUNT, buffer contents irrelevant, out_valid = 0. The next frame parses normally.

Test Plan:
- Good frame: bytes A5 02 42 6F B3 via rx_done pulses; out_ready=1 -> frame_ok pulse, frame_len=2. Stream 42 (out_last=0), then 6F (out_last=1). Then back to HUNT.
- Backpressure: same frame with out_ready=0 for 5 cycles -> out_data holds 42 with out_valid=1; 6F follows only after ready is raised. No overrun.
- Errors:
  - A5 02 42 6F B4 -> err_csum, no out_valid.
  - A5 00 -> err_len.
  - A5 11 -> err_len (MAX_LEN=16). The following A5 01 7E 7F then yields frame_ok and out_data 7E.
- Timeout/hunt: leading junk 00 FF before A5 03 01 02 -> no error. Stall TIMEOUT_CLKS -> err_timeout. A new A5 01 10 11 then parses OK.
- Overrun and held rx_done:
  - Send a byte during DRAIN with out_ready=0 -> overrun pulse; drained data unchanged.
  - rx_done held high 3 cycles -> counted as one byte.
- Reset mid-frame: assert rst after A5 02 42. After release, A5 02 42 6F B3 -> correct 42, 6F output; rx_done high at release is not counted.

Source files
------------

// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser: assembles SYNC/LEN/payload/CSUM frames from UART
// receiver bytes and releases verified payload as a valid/ready stream.
module uart_rx_frame_parser #(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 8680
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] frame_len,
    output logic       frame_ok,
    output logic       err_len,
    output logic       err_csum,
    output logic       err_timeout,
    output logic       overrun
);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAY,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t        state;
    logic          rx_done_d;
    logic [7:0]    len;
    logic [7:0]    sum;
    logic [7:0]    idx;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    mem [MAX_LEN];

    logic       ev;
    logic       tmo_exp;
    logic       draining;
    logic       is_last;
    logic [7:0] cur;

    assign ev        = rx_done & ~rx_done_d;
    assign tmo_exp   = (tmo_cnt == TMO_LAST);
    assign draining  = (state == S_DRAIN);
    assign cur       = mem[idx[AW-1:0]];
    assign is_last   = (idx == len - 8'd1);
    assign out_valid = draining;
    assign out_data  = draining ? cur : 8'h00;
    assign out_last  = draining & is_last;

    // Payload capture; contents only matter once a frame verifies.
    always_ff @(posedge clk) begin
        if (state == S_PAY && ev)
            mem[idx[AW-1:0]] <= rx_data;
    end

    // Frame parser FSM with registered status pulses and timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_HUNT;
            rx_done_d   <= 1'b1;
            len         <= 8'd0;
            sum         <= 8'd0;
            idx         <= 8'd0;
            tmo_cnt     <= '0;
            frame_len   <= 8'd0;
            frame_ok    <= 1'b0;
            err_len     <= 1'b0;
            err_csum    <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            rx_done_d   <= rx_done;
            frame_ok    <= 1'b0;
            err_len     <= 1'b0;
            err_csum    <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
            case (state)
                S_HUNT: begin
                    tmo_cnt <= '0;
                    if (ev && rx_data == SYNC_BYTE)
                        state <= S_LEN;
                end
                S_LEN: begin
                    if (ev) begin
                        tmo_cnt <= '0;
                        if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                            err_len <= 1'b1;
                            state   <= S_HUNT;
                        end else begin
                            len   <= rx_data;
                            sum   <= rx_data;
                            idx   <= 8'd0;
                            state <= S_PAY;
                        end
                    end else if (tmo_exp) begin
                        err_timeout <= 1'b1;
                        state       <= S_HUNT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_PAY: begin
                    if (ev) begin
                        tmo_cnt <= '0;
                        sum     <= sum + rx_data;
                        idx     <= idx + 8'd1;
                        if (idx + 8'd1 == len)
                            state <= S_CSUM;
                    end else if (tmo_exp) begin
                        err_timeout <= 1'b1;
                        state       <= S_HUNT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_CSUM: begin
                    if (ev) begin
                        tmo_cnt <= '0;
                        if (rx_data == sum) begin
                            frame_len <= len;
                            frame_ok  <= 1'b1;
                            idx       <= 8'd0;
                            state     <= S_DRAIN;
                        end else begin
                            err_csum <= 1'b1;
                            state    <= S_HUNT;
                        end
                    end else if (tmo_exp) begin
                        err_timeout <= 1'b1;
                        state       <= S_HUNT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_DRAIN: begin
                    tmo_cnt <= '0;
                    if (ev)
                        overrun <= 1'b1;
                    if (out_ready) begin
                        idx <= idx + 8'd1;
                        if (is_last)
                            state <= S_HUNT;
                    end
                end
                default: begin
                    state <= S_HUNT;
                end
            endcase
        end
    end

endmodule
